// File: rtl/jtkunio_adpcm_enc.sv
// OKI MSM5205-compatible 4-bit ADPCM encoder.
// Each signed PCM sample becomes one nibble {sign,m2,m1,m0}. The encoder reconstructs
// the predictor with the same arithmetic as the jt5205 decoder, so the decoder tracks
// it exactly. Two nibbles are packed per output byte.
module jtkunio_adpcm_enc #(
  parameter int SW       = 12,
  parameter bit LOWFIRST = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          clr_i,
  input  logic          flush_i,
  input  logic          s_valid_i,
  input  logic [SW-1:0] s_data_i,
  output logic          s_ready_o,
  output logic          b_valid_o,
  output logic [7:0]    b_data_o,
  input  logic          b_ready_i,
  output logic [11:0]   pred_o,
  output logic [5:0]    step_idx_o
);

  typedef enum logic [2:0] {IDLE, DIFF, B2, B1, B0, UPD} state_t;

  // Standard 49-entry OKI step table, same contents as jt5205
  function automatic logic [12:0] step_lut(input logic [5:0] i);
    case (i)
      6'd0:  return 13'd16;   6'd1:  return 13'd17;   6'd2:  return 13'd19;
      6'd3:  return 13'd21;   6'd4:  return 13'd23;   6'd5:  return 13'd25;
      6'd6:  return 13'd28;   6'd7:  return 13'd31;   6'd8:  return 13'd34;
      6'd9:  return 13'd37;   6'd10: return 13'd41;   6'd11: return 13'd45;
      6'd12: return 13'd50;   6'd13: return 13'd55;   6'd14: return 13'd60;
      6'd15: return 13'd66;   6'd16: return 13'd73;   6'd17: return 13'd80;
      6'd18: return 13'd88;   6'd19: return 13'd97;   6'd20: return 13'd107;
      6'd21: return 13'd118;  6'd22: return 13'd130;  6'd23: return 13'd143;
      6'd24: return 13'd157;  6'd25: return 13'd173;  6'd26: return 13'd190;
      6'd27: return 13'd209;  6'd28: return 13'd230;  6'd29: return 13'd253;
      6'd30: return 13'd279;  6'd31: return 13'd307;  6'd32: return 13'd337;
      6'd33: return 13'd371;  6'd34: return 13'd408;  6'd35: return 13'd449;
      6'd36: return 13'd494;  6'd37: return 13'd544;  6'd38: return 13'd598;
      6'd39: return 13'd658;  6'd40: return 13'd724;  6'd41: return 13'd796;
      6'd42: return 13'd876;  6'd43: return 13'd963;  6'd44: return 13'd1060;
      6'd45: return 13'd1166; 6'd46: return 13'd1282; 6'd47: return 13'd1411;
      default: return 13'd1552;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [11:0]        x_q, x_d;
  logic [12:0]        a_q, a_d;
  logic               sign_q, sign_d, m2_q, m2_d, m1_q, m1_d, m0_q, m0_d;
  logic [11:0]        pred_q, pred_d;
  logic [5:0]         idx_q, idx_d;
  logic [3:0]         half_q, half_d;
  logic               half_full_q, half_full_d;
  logic               bval_q, bval_d;
  logic [7:0]         bdata_q, bdata_d;
  logic               fpend_q, fpend_d;

  logic               sready;
  logic               flush_eff;
  logic [11:0]        sample;
  logic [12:0]        step, d13, delta;
  logic [3:0]         nib;
  logic signed [13:0] psum;
  logic signed [7:0]  adj, inext;

  assign sample    = s_data_i[SW-1 -: 12];
  assign flush_eff = flush_i | fpend_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      a_q         <= '0;
      sign_q      <= 1'b0;
      m2_q        <= 1'b0;
      m1_q        <= 1'b0;
      m0_q        <= 1'b0;
      pred_q      <= '0;
      idx_q       <= '0;
      half_q      <= '0;
      half_full_q <= 1'b0;
      bval_q      <= 1'b0;
      bdata_q     <= '0;
      fpend_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      a_q         <= a_d;
      sign_q      <= sign_d;
      m2_q        <= m2_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      pred_q      <= pred_d;
      idx_q       <= idx_d;
      half_q      <= half_d;
      half_full_q <= half_full_d;
      bval_q      <= bval_d;
      bdata_q     <= bdata_d;
      fpend_q     <= fpend_d;
    end
  end

  // Next-state, successive-approximation quantiser, predictor update and byte packing
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    a_d         = a_q;
    sign_d      = sign_q;
    m2_d        = m2_q;
    m1_d        = m1_q;
    m0_d        = m0_q;
    pred_d      = pred_q;
    idx_d       = idx_q;
    half_d      = half_q;
    half_full_d = half_full_q;
    bval_d      = bval_q;
    bdata_d     = bdata_q;
    fpend_d     = fpend_q | flush_i;
    sready      = 1'b0;
    step        = step_lut(idx_q);
    d13         = '0;
    delta       = '0;
    psum        = '0;
    adj         = '0;
    inext       = '0;
    nib         = {sign_q, m2_q, m1_q, m0_q};

    if (bval_q && b_ready_i) bval_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bval_q) begin
          if (flush_eff) begin
            fpend_d = 1'b0;
            if (half_full_q) begin
              bval_d      = 1'b1;
              bdata_d     = LOWFIRST ? {4'h0, half_q} : {half_q, 4'h0};
              half_full_d = 1'b0;
            end
          end
          if (!(flush_eff && half_full_q)) begin
            sready = 1'b1;
            if (s_valid_i) begin
              x_d     = sample;
              state_d = DIFF;
            end
          end
        end
      end
      DIFF: begin
        d13     = {x_q[11], x_q} - {pred_q[11], pred_q};
        sign_d  = d13[12];
        a_d     = d13[12] ? (13'd0 - d13) : d13;
        state_d = B2;
      end
      B2: begin
        m2_d    = (a_q >= step);
        if (m2_d) a_d = a_q - step;
        state_d = B1;
      end
      B1: begin
        m1_d    = (a_q >= (step >> 1));
        if (m1_d) a_d = a_q - (step >> 1);
        state_d = B0;
      end
      B0: begin
        m0_d    = (a_q >= (step >> 2));
        state_d = UPD;
      end
      UPD: begin
        delta = (step >> 3) + (m2_q ? step : 13'd0) + (m1_q ? (step >> 1) : 13'd0)
              + (m0_q ? (step >> 2) : 13'd0);
        if (sign_q) psum = $signed({{2{pred_q[11]}}, pred_q}) - $signed({1'b0, delta});
        else        psum = $signed({{2{pred_q[11]}}, pred_q}) + $signed({1'b0, delta});
        if (psum > 14'sd2047)       pred_d = 12'h7FF;
        else if (psum < -14'sd2048) pred_d = 12'h800;
        else                        pred_d = psum[11:0];
        case ({m2_q, m1_q, m0_q})
          3'd4:    adj = 8'sd2;
          3'd5:    adj = 8'sd4;
          3'd6:    adj = 8'sd6;
          3'd7:    adj = 8'sd8;
          default: adj = -8'sd1;
        endcase
        inext = $signed({2'b00, idx_q}) + adj;
        if (inext < 8'sd0)       idx_d = 6'd0;
        else if (inext > 8'sd48) idx_d = 6'd48;
        else                     idx_d = inext[5:0];
        if (half_full_q) begin
          bval_d      = 1'b1;
          bdata_d     = LOWFIRST ? {nib, half_q} : {half_q, nib};
          half_full_d = 1'b0;
        end else begin
          half_d      = nib;
          half_full_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr_i) begin
      state_d     = IDLE;
      pred_d      = '0;
      idx_d       = '0;
      half_d      = '0;
      half_full_d = 1'b0;
      bval_d      = 1'b0;
      bdata_d     = '0;
      fpend_d     = 1'b0;
    end
    if (clr_i || rst) sready = 1'b0;
  end

  assign s_ready_o  = sready;
  assign b_valid_o  = bval_q;
  assign b_data_o   = bdata_q;
  assign pred_o     = pred_q;
  assign step_idx_o = idx_q;

endmodule

// File: tb/tb_jtkunio_adpcm_enc.sv
// Directed bench for jtkunio_adpcm_enc: two encoders (LOWFIRST=1 and 0) share stimulus.
module tb_jtkunio_adpcm_enc;

  logic        clk = 1'b0;
  logic        rst, clr, flush, s_valid, b_ready;
  logic [11:0] s_data;
  logic        s_ready, b_valid, s_ready0, b_valid0;
  logic [7:0]  b_data, b_data0;
  logic [11:0] pred, pred0;
  logic [5:0]  sidx, sidx0;

  int total = 0;
  int bad   = 0;
  int mpred, midx;
  int tbl[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,
                  130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,
                  658,724,796,876,963,1060,1166,1282,1411,1552};

  jtkunio_adpcm_enc #(.SW(12), .LOWFIRST(1'b1)) u1 (
    .rst(rst), .clk(clk), .clr_i(clr), .flush_i(flush), .s_valid_i(s_valid),
    .s_data_i(s_data), .s_ready_o(s_ready), .b_valid_o(b_valid), .b_data_o(b_data),
    .b_ready_i(b_ready), .pred_o(pred), .step_idx_o(sidx));

  jtkunio_adpcm_enc #(.SW(12), .LOWFIRST(1'b0)) u0 (
    .rst(rst), .clk(clk), .clr_i(clr), .flush_i(flush), .s_valid_i(s_valid),
    .s_data_i(s_data), .s_ready_o(s_ready0), .b_valid_o(b_valid0), .b_data_o(b_data0),
    .b_ready_i(b_ready), .pred_o(pred0), .step_idx_o(sidx0));

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic do_clr();
    clr = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL clr_ready: got %b want 0", s_ready); end
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic send(input logic [11:0] v);
    int n = 0;
    s_valid = 1'b1;
    s_data  = v;
    #1;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!s_ready) begin
      total++; bad++;
      $display("[TB] FAIL send_timeout: s_ready got %b want 1", s_ready);
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_byte(output logic [7:0] d);
    int n = 0;
    while (!b_valid && n < 60) begin @(posedge clk); #1; n++; end
    if (!b_valid) begin
      total++; bad++;
      $display("[TB] FAIL byte_timeout: b_valid got %b want 1", b_valid);
    end
    d = b_data;
  endtask

  task automatic dec_nib(input logic [3:0] n);
    int st, dl;
    st = tbl[midx];
    dl = st / 8;
    if (n[2]) dl += st;
    if (n[1]) dl += st / 2;
    if (n[0]) dl += st / 4;
    mpred = n[3] ? mpred - dl : mpred + dl;
    if (mpred > 2047) mpred = 2047;
    if (mpred < -2048) mpred = -2048;
    case (n[2:0])
      3'd4: midx += 2;
      3'd5: midx += 4;
      3'd6: midx += 6;
      3'd7: midx += 8;
      default: midx -= 1;
    endcase
    if (midx < 0) midx = 0;
    if (midx > 48) midx = 48;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; b_ready = 1'b1;
    @(posedge clk); #1;
    total += 5;
    if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", s_ready); end
    if (b_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_bvalid: got %b want 0", b_valid); end
    if (b_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_bdata: got %h want 00", b_data); end
    if (pred !== 12'h000) begin bad++; $display("[TB] FAIL rst_pred: got %h want 000", pred); end
    if (sidx !== 6'd0)    begin bad++; $display("[TB] FAIL rst_idx: got %0d want 0", sidx); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_pair();
    logic [7:0] d;
    do_clr();
    send(12'd100);
    send(12'd0);
    wait_byte(d);
    total += 5;
    if (d !== 8'hB7)       begin bad++; $display("[TB] FAIL pair_low: got %h want B7", d); end
    if (b_data0 !== 8'h7B) begin bad++; $display("[TB] FAIL pair_high: got %h want 7B", b_data0); end
    if (b_valid0 !== 1'b1) begin bad++; $display("[TB] FAIL pair_bvalid0: got %b want 1", b_valid0); end
    if (pred !== 12'd1)    begin bad++; $display("[TB] FAIL pair_pred: got %0d want 1", pred); end
    if (sidx !== 6'd7)     begin bad++; $display("[TB] FAIL pair_idx: got %0d want 7", sidx); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [7:0] d;
    int seen = 0;
    do_clr();
    send(12'd100);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_byte(d);
    total += 3;
    if (d !== 8'h07)     begin bad++; $display("[TB] FAIL flush_byte: got %h want 07", d); end
    if (pred !== 12'd30) begin bad++; $display("[TB] FAIL flush_pred: got %0d want 30", pred); end
    if (sidx !== 6'd8)   begin bad++; $display("[TB] FAIL flush_idx: got %0d want 8", sidx); end
    @(posedge clk); #1;
    total++;
    if (b_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_onecycle: got %b want 0", b_valid); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b_valid) seen++;
      @(posedge clk); #1;
    end
    total += 2;
    if (seen != 0)       begin bad++; $display("[TB] FAIL flush_empty: got %0d bytes want 0", seen); end
    if (pred !== 12'd30) begin bad++; $display("[TB] FAIL flush_keep_pred: got %0d want 30", pred); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int unstable = 0;
    do_clr();
    b_ready = 1'b0;
    send(12'd100);
    send(12'd0);
    wait_byte(d);
    s_valid = 1'b1;
    s_data  = 12'd100;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_valid !== 1'b1 || b_data !== 8'hB7 || s_ready !== 1'b0) unstable++;
    end
    total++;
    if (unstable != 0) begin bad++; $display("[TB] FAIL bp_hold: got %0d bad cycles want 0", unstable); end
    b_ready = 1'b1;
    s_valid = 1'b0;
    send(12'd100);
    send(12'd0);
    wait_byte(d);
    total += 3;
    if (d !== 8'hB7)     begin bad++; $display("[TB] FAIL bp_resume_byte: got %h want B7", d); end
    if (pred !== 12'd0)  begin bad++; $display("[TB] FAIL bp_resume_pred: got %0d want 0", pred); end
    if (sidx !== 6'd14)  begin bad++; $display("[TB] FAIL bp_resume_idx: got %0d want 14", sidx); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [7:0] d;
    do_clr();
    for (int i = 0; i < 60; i++) send(12'h7FF);
    wait_byte(d);
    total += 2;
    if (pred !== 12'h7FF) begin bad++; $display("[TB] FAIL sat_pos_pred: got %h want 7FF", pred); end
    if (sidx !== 6'd0)    begin bad++; $display("[TB] FAIL sat_pos_idx: got %0d want 0", sidx); end
    do_clr();
    for (int i = 0; i < 200; i++) send((i % 2 == 0) ? 12'h7FF : 12'h800);
    wait_byte(d);
    total += 2;
    if (pred !== 12'hC6C) begin bad++; $display("[TB] FAIL sat_alt_pred: got %h want C6C", pred); end
    if (sidx !== 6'd48)   begin bad++; $display("[TB] FAIL sat_alt_idx: got %0d want 48", sidx); end
  endtask

  task automatic test_loopback();
    logic [7:0]  d;
    logic [11:0] v;
    int errs = 0;
    do_clr();
    mpred = 0;
    midx  = 0;
    for (int i = 0; i < 40; i += 2) begin
      v = 12'((i * 1237 + 311) % 4096);
      send(v);
      v = 12'(((i + 1) * 1237 + 311) % 4096);
      send(v);
      wait_byte(d);
      dec_nib(d[3:0]);
      dec_nib(d[7:4]);
      if (int'($signed(pred)) != mpred || int'(sidx) != midx) begin
        errs++;
        $display("[TB] FAIL loop_byte%0d: pred %0d idx %0d want pred %0d idx %0d",
                 i / 2, $signed(pred), sidx, mpred, midx);
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    do_clr();
    send(12'd100);
    send(12'd0);
    wait_byte(d);
    @(posedge clk); #1;
    send(12'd100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total += 5;
    if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready: got %b want 0", s_ready); end
    if (b_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_bvalid: got %b want 0", b_valid); end
    if (b_data !== 8'h00) begin bad++; $display("[TB] FAIL mid_bdata: got %h want 00", b_data); end
    if (pred !== 12'h000) begin bad++; $display("[TB] FAIL mid_pred: got %0d want 0", pred); end
    if (sidx !== 6'd0)    begin bad++; $display("[TB] FAIL mid_idx: got %0d want 0", sidx); end
    @(posedge clk); #1;
    rst = 1'b0;
    send(12'd100);
    send(12'd0);
    wait_byte(d);
    total += 3;
    if (d !== 8'hB7)     begin bad++; $display("[TB] FAIL mid_after_byte: got %h want B7", d); end
    if (pred !== 12'd1)  begin bad++; $display("[TB] FAIL mid_after_pred: got %0d want 1", pred); end
    if (sidx !== 6'd7)   begin bad++; $display("[TB] FAIL mid_after_idx: got %0d want 7", sidx); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_pair();
    test_flush();
    test_backpressure();
    test_saturation();
    test_loopback();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
